// File: rtl/inst_issue_ctrl.sv
// inst_issue_ctrl: instruction FIFO plus RAW scoreboard issuing at most one instruction per cycle.
// Ports: in_valid/in_inst/in_ready enqueue side; issue_en/flush control; issue_inst/issue_valid
// registered issue slot (0 on bubble); fifo_count, busy, stall_cnt, issued_cnt status.
module inst_issue_ctrl #(
  parameter int DEPTH  = 4,
  parameter int WB_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [31:0]                in_inst,
  output logic                       in_ready,
  input  logic                       issue_en,
  input  logic                       flush,
  output logic [31:0]                issue_inst,
  output logic                       issue_valid,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       busy,
  output logic [15:0]                stall_cnt,
  output logic [15:0]                issued_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, RUN, HAZ} state_t;
  state_t state_q, state_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WB_LAT-1:0] sb_v_q, sb_v_d;
  logic [4:0] sb_dst_q [WB_LAT];
  logic [4:0] sb_dst_d [WB_LAT];
  logic [31:0] issue_inst_q, issue_inst_d;
  logic issue_valid_q, issue_valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, issued_cnt_q, issued_cnt_d;
  logic [31:0] head;
  logic [4:0] src_a, src_b, head_dst;
  logic nonempty, hazard, push, pop, stall;
  // I-type has a single source; zeroing src_b makes it never match.
  assign head     = mem_q[rd_q];
  assign src_a    = head[25:21];
  assign src_b    = head[31] ? 5'd0 : head[20:16];
  assign head_dst = head[31] ? head[20:16] : head[15:11];
  assign nonempty = cnt_q != '0;
  // Scoreboard entries are only valid for nonzero dests, so a zero source never matches a valid entry.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < WB_LAT; k++)
      if (nonempty && sb_v_q[k] && ((src_a != 5'd0 && sb_dst_q[k] == src_a) ||
                                    (src_b != 5'd0 && sb_dst_q[k] == src_b)))
        hazard = 1'b1;
  end
  always_comb begin
    in_ready = cnt_q < CW'(DEPTH);
    push     = in_valid && in_ready && !flush;
    pop      = nonempty && !hazard && issue_en && !flush;
    stall    = nonempty && hazard && issue_en && !flush;
  end
  always_comb begin
    state_d = flush ? IDLE :
              state_q == IDLE ? (cnt_d != '0 ? RUN : IDLE) :
              state_q == RUN  ? (hazard ? HAZ : (cnt_d == '0 ? IDLE : RUN)) :
                                (hazard ? HAZ : RUN);
  end
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = in_inst;
    wr_d  = flush ? '0 : wr_q + PW'(push);
    rd_d  = flush ? '0 : rd_q + PW'(pop);
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    // The scoreboard shifts every cycle, flush included, since in-flight writes still land.
    sb_v_d[0]   = pop && head_dst != 5'd0;
    sb_dst_d[0] = pop ? head_dst : 5'd0;
    for (int k = 1; k < WB_LAT; k++) begin
      sb_v_d[k]   = sb_v_q[k-1];
      sb_dst_d[k] = sb_dst_q[k-1];
    end
    issue_inst_d  = pop ? head : 32'h0;
    issue_valid_d = pop;
    stall_cnt_d   = stall_cnt_q + 16'((stall && stall_cnt_q != 16'hFFFF) ? 1 : 0);
    issued_cnt_d  = issued_cnt_q + 16'((pop && issued_cnt_q != 16'hFFFF) ? 1 : 0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_q         <= '{default: '0};
      wr_q          <= '0;
      rd_q          <= '0;
      cnt_q         <= '0;
      sb_v_q        <= '0;
      sb_dst_q      <= '{default: '0};
      issue_inst_q  <= '0;
      issue_valid_q <= 1'b0;
      stall_cnt_q   <= '0;
      issued_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
      sb_v_q        <= sb_v_d;
      sb_dst_q      <= sb_dst_d;
      issue_inst_q  <= issue_inst_d;
      issue_valid_q <= issue_valid_d;
      stall_cnt_q   <= stall_cnt_d;
      issued_cnt_q  <= issued_cnt_d;
    end
  end
  assign issue_inst  = issue_inst_q;
  assign issue_valid = issue_valid_q;
  assign fifo_count  = cnt_q;
  assign busy        = nonempty || (|sb_v_q);
  assign stall_cnt   = stall_cnt_q;
  assign issued_cnt  = issued_cnt_q;
endmodule

// File: tb/tb_inst_issue_ctrl.sv
// tb_inst_issue_ctrl: directed and random stimulus against a queue-based reference model.
module tb_inst_issue_ctrl;
  localparam int DEPTH  = 4;
  localparam int WB_LAT = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, issue_en = 1'b0, flush = 1'b0;
  logic [31:0] in_inst = '0;
  logic in_ready, issue_valid, busy;
  logic [31:0] issue_inst;
  logic [2:0] fifo_count;
  logic [15:0] stall_cnt, issued_cnt;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] q[$];
  int last_issue[32];
  int e = 0, exp_stall = 0, exp_issued = 0;
  int iss_edges[$];
  logic [31:0] exp_inst;
  logic exp_valid;
  inst_issue_ctrl #(.DEPTH(DEPTH), .WB_LAT(WB_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
    .issue_en(issue_en), .flush(flush), .issue_inst(issue_inst), .issue_valid(issue_valid),
    .fifo_count(fifo_count), .busy(busy), .stall_cnt(stall_cnt), .issued_cnt(issued_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] r_inst(input int rs, input int rt, input int rd);
    logic [10:0] tag = 11'($urandom);
    return {1'b0, 5'd0, 5'(rs), 5'(rt), 5'(rd), tag};
  endfunction
  function automatic logic [31:0] i_inst(input int rs, input int rt);
    logic [15:0] imm = 16'($urandom);
    return {1'b1, 5'd0, 5'(rs), 5'(rt), imm};
  endfunction
  // A register is pending if its producer issued within the last WB_LAT edges before edge `at`.
  function automatic bit pending(input logic [4:0] r, input int at);
    return r != 5'd0 && (at - last_issue[r]) <= WB_LAT;
  endfunction
  function automatic bit exp_busy();
    if (q.size() != 0) return 1'b1;
    for (int r = 1; r < 32; r++) if (e - last_issue[r] < WB_LAT) return 1'b1;
    return 1'b0;
  endfunction
  task automatic model_clear();
    q.delete();
    for (int r = 0; r < 32; r++) last_issue[r] = -100;
    exp_stall = 0;
    exp_issued = 0;
    iss_edges.delete();
  endtask
  task automatic step(input logic v, input logic [31:0] inst, input logic en, input logic fl);
    logic [31:0] h;
    logic haz, iss, rdy, ne;
    logic [4:0] d;
    in_valid = v; in_inst = inst; issue_en = en; flush = fl;
    e++;
    rdy = q.size() < DEPTH;
    ne = q.size() != 0;
    h = ne ? q[0] : 32'h0;
    haz = ne && (pending(h[25:21], e) || (!h[31] && pending(h[20:16], e)));
    iss = ne && !haz && en && !fl;
    if (ne && haz && en && !fl) exp_stall++;
    d = h[31] ? h[20:16] : h[15:11];
    if (fl) q.delete();
    else begin
      if (iss) void'(q.pop_front());
      if (v && rdy) q.push_back(inst);
    end
    if (iss) begin
      exp_issued++;
      if (d != 5'd0) last_issue[d] = e;
    end
    exp_valid = iss;
    exp_inst = iss ? h : 32'h0;
    @(posedge clk);
    #1;
    if (issue_valid === 1'b1) iss_edges.push_back(e);
    chk("issue_valid", 32'(issue_valid), 32'(exp_valid));
    chk("issue_inst", issue_inst, exp_inst);
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall > 65535 ? 65535 : exp_stall));
    chk("issued_cnt", 32'(issued_cnt), 32'(exp_issued > 65535 ? 65535 : exp_issued));
    chk("busy", 32'(busy), 32'(exp_busy()));
  endtask
  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, en, 1'b0);
  endtask
  // Asserts reset between edges and checks outputs before any further edge.
  task automatic do_reset();
    #2;
    rst = 1'b1; in_valid = 1'b0; issue_en = 1'b0; flush = 1'b0;
    #1;
    chk("rst_issue_valid", 32'(issue_valid), 32'h0);
    chk("rst_issue_inst", issue_inst, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_fifo_count", 32'(fifo_count), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_issued_cnt", 32'(issued_cnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    model_clear();
    do_reset();
    // Independent stream: four back-to-back issues.
    for (int i = 1; i <= 4; i++) step(1'b1, r_inst(0, 0, i), 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("ind_issues", 32'(iss_edges.size()), 32'd4);
    chk("ind_span", 32'(iss_edges[3] - iss_edges[0]), 32'd3);
    chk("ind_issued_cnt", 32'(issued_cnt), 32'd4);
    chk("ind_stall_cnt", 32'(stall_cnt), 32'd0);
    // RAW hazard on r5: dependent issues WB_LAT+1 cycles later.
    do_reset();
    step(1'b1, i_inst(0, 5), 1'b1, 1'b0);
    step(1'b1, r_inst(5, 0, 6), 1'b1, 1'b0);
    idle(5, 1'b1);
    chk("raw_issues", 32'(iss_edges.size()), 32'd2);
    chk("raw_gap", 32'(iss_edges[1] - iss_edges[0]), 32'd3);
    chk("raw_stall_cnt", 32'(stall_cnt), 32'd2);
    // r0 destination creates no hazard.
    do_reset();
    step(1'b1, i_inst(0, 0), 1'b1, 1'b0);
    step(1'b1, r_inst(0, 0, 7), 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("r0_gap", 32'(iss_edges[1] - iss_edges[0]), 32'd1);
    chk("r0_stall_cnt", 32'(stall_cnt), 32'd0);
    // Full FIFO with issue blocked, then drain in order.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, r_inst(0, 0, i + 10), 1'b0, 1'b0);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    idle(6, 1'b1);
    chk("full_issued_cnt", 32'(issued_cnt), 32'd4);
    chk("full_stall_cnt", 32'(stall_cnt), 32'd0);
    // Flush while a hazard is pending with three queued entries.
    do_reset();
    step(1'b1, i_inst(0, 9), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, r_inst(9, 0, 20 + i), 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("haz_count", 32'(fifo_count), 32'd3);
    step(1'b1, r_inst(9, 9, 25), 1'b1, 1'b1);
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_busy", 32'(busy), 32'd1);
    step(1'b1, r_inst(0, 0, 26), 1'b1, 1'b0);
    step(1'b1, r_inst(9, 0, 27), 1'b1, 1'b0);
    idle(4, 1'b1);
    chk("flush_issued_cnt", 32'(issued_cnt), 32'd3);
    // Random traffic over a small register set to provoke hazards.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins;
      ins = ($urandom_range(0, 1) == 0) ? r_inst($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3))
                                        : i_inst($urandom_range(0, 3), $urandom_range(0, 3));
      step($urandom_range(0, 9) < 7, ins, $urandom_range(0, 9) < 8, $urandom_range(0, 15) == 0);
      if (i == 300) begin
        do_reset();
        idle(1, 1'b1);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/inst_issue_ctrl.md
Name: inst_issue_ctrl

Overview:
- Instruction issue controller in front of the two-stage datapath (decode/register-file stage feeding the ALU/write-back stage).
- Buffers incoming instructions in a small FIFO and issues at most one per cycle.
- Tracks in-flight destination registers in a scoreboard and inserts NOP bubbles on read-after-write hazards, so no instruction reads a register before its write-back completes.
- Keeps issue and stall statistics.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- WB_LAT, 2, cycles from issue until the register file holds the result (scoreboard depth, >=1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_inst valid.
- in_inst  input  32  instruction to enqueue.
- in_ready  output  1  FIFO can accept.
- issue_en  input  1  downstream permits issue this cycle; 0 forces a bubble.
- flush  input  1  synchronous; discard all queued instructions.
- issue_inst  output  32  registered instruction to datapath; 32'h0 on bubble.
- issue_valid  output  1  registered; 1 when issue_inst is a real instruction.
- fifo_count  output  log2(DEPTH)+1  queued entries.
- busy  output  1  FIFO non-empty or scoreboard holds a valid entry.
- stall_cnt  output  16  hazard-bubble cycles, saturating.
- issued_cnt  output  16  issued instructions, saturating.

Behaviour:
- Decoded fields:
  - Sources: rs = inst[25:21].
  - R-type (inst[31]=0): sources rs and rt = inst[20:16]; dest rd = inst[15:11].
  - I-type (inst[31]=1): source rs only; dest rt.
  - Register 0 is never a hazard source or dest.
- Reset (async): FIFO empty, scoreboard invalid, issue_inst=0, issue_valid=0, counters=0, state=IDLE, in_ready=1.
- Enqueue:
  - in_ready = (fifo_count<DEPTH).
  - Push on in_valid&&in_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - When full, in_ready=0 even if a pop occurs that cycle; there is no bypass.
  - Pointers wrap modulo DEPTH.
- Scoreboard: WB_LAT entries {valid, dest[4:0]}. Every clock edge:
  - sb[0] <= issuing ? {dest!=0, dest} : invalid.
  - sb[k] <= sb[k-1].
- Hazard: head source matches any valid sb entry's dest. A dependent of an instruction issued in cycle t issues no earlier than cycle t+WB_LAT+1.
- Issue condition: fifo non-empty && !hazard && issue_en && !flush.
  - On the issuing edge, issue_inst<=head and issue_valid<=1; head pops.
  - Otherwise issue_inst<=0 and issue_valid<=0.
  - Latency: an instruction pushed into an empty FIFO with no hazard appears on issue_inst one cycle after the push edge (two edges after in_valid is sampled).
- State machine (registered):
  - IDLE: FIFO empty. Goes to RUN when fifo non-empty.
  - RUN: issuing. Goes to HAZ if head hazards, and to IDLE if empty after pop.
  - HAZ: bubbling on hazard. Goes to RUN when the hazard clears.
  - flush from any state clears the FIFO next edge and goes to IDLE; the scoreboard keeps shifting, because in-flight writes still complete.
  - Push coincident with flush is discarded.
- Counters:
  - stall_cnt increments on each edge where fifo is non-empty, hazard=1, issue_en=1 and flush=0.
  - issue_en=0 bubbles are not counted.
  - issued_cnt increments per issue.
  - Both hold at 16'hFFFF.
- busy is combinational from FIFO and scoreboard state.
- Reset mid-operation drops queued and in-flight tracking immediately; outputs return to reset values asynchronously.

Test Plan:
- Independent stream: push R-type rd=1,2,3,4 (sources r0) back-to-back, issue_en=1 -> issue_valid high 4 consecutive cycles, issued_cnt=4, stall_cnt=0.
- RAW hazard, WB_LAT=2: push I-type rt=5, then R-type rs=5 -> second instruction issues exactly 3 cycles after the first; two bubbles (issue_inst=0); stall_cnt=2.
- r0 destination: I-type rt=0, then rs=0 consumer -> no stall; consecutive issue.
- Full FIFO: issue_en=0, push 5 instructions -> in_ready drops after 4, fifo_count=4, 5th not accepted; raise issue_en -> 4 issue in order.
- Flush during HAZ: hazard pending with 3 queued, pulse flush -> fifo_count=0 next cycle, state IDLE; new independent push issues normally; later dependent of pre-flush issue still stalls until its scoreboard entry expires.
- Async reset mid-stream: assert rst between edges -> issue_valid=0, counters=0, in_ready=1 immediately.
